// File: rtl/stream_pixel_unit_pkg.sv
// Shared constants for the per-pixel compositing unit and its texel fetch.
package stream_pixel_unit_pkg;

  localparam logic [1:0] DMODE_GE     = 2'd0;
  localparam logic [1:0] DMODE_GT     = 2'd1;
  localparam logic [1:0] DMODE_ALWAYS = 2'd2;
  localparam logic [1:0] DMODE_NEVER  = 2'd3;

  // Default transparent color: all ones, truncated to the color width by users.
  localparam logic [31:0] DEFAULT_COLOR_KEY = '1;

endpackage

// File: rtl/stream_pixel_unit_texel_fetch.sv
// Combinational coverage test and texel select for one fixed screen pixel.
module stream_texel_fetch #(
  parameter int POS_X   = 0,
  parameter int POS_Y   = 0,
  parameter int TEX_W   = 16,
  parameter int TEX_H   = 2,
  parameter int COLOR_W = 8,
  parameter int POS_W   = 8
) (
  input  logic [TEX_H*TEX_W*COLOR_W-1:0] i_texture_data,
  input  logic [POS_W-1:0]               i_start_x,
  input  logic [POS_W-1:0]               i_start_y,
  output logic                           o_covered,
  output logic [COLOR_W-1:0]             o_texel
);

  localparam logic [POS_W:0] C_POS_X = (POS_W+1)'(POS_X);
  localparam logic [POS_W:0] C_POS_Y = (POS_W+1)'(POS_Y);
  localparam logic [POS_W:0] C_TEX_W = (POS_W+1)'(TEX_W);
  localparam logic [POS_W:0] C_TEX_H = (POS_W+1)'(TEX_H);

  logic [POS_W:0] w_dx;
  logic [POS_W:0] w_dy;
  logic [31:0]    w_idx;

  // One extra bit holds the sign; both operands are non-negative so it never overflows.
  assign w_dx = C_POS_X - {1'b0, i_start_x};
  assign w_dy = C_POS_Y - {1'b0, i_start_y};

  assign o_covered = !w_dx[POS_W] && (w_dx < C_TEX_W) &&
                     !w_dy[POS_W] && (w_dy < C_TEX_H);

  assign w_idx = 32'(w_dy) * TEX_W + 32'(w_dx);

  always_comb begin
    o_texel = '0;
    for (int k = 0; k < TEX_W*TEX_H; k++) begin
      if (o_covered && (w_idx == 32'(k))) begin
        o_texel = i_texture_data[k*COLOR_W +: COLOR_W];
      end
    end
  end

endmodule

// File: rtl/stream_pixel_unit.sv
// One screen pixel: two-stage fragment compositor with depth test, color key and frame clear.
module stream_pixel_unit
  import stream_pixel_unit_pkg::*;
#(
  parameter int POS_X   = 0,
  parameter int POS_Y   = 0,
  parameter int TEX_W   = 16,
  parameter int TEX_H   = 2,
  parameter int COLOR_W = 8,
  parameter int DEPTH_W = 8,
  parameter int POS_W   = 8,
  parameter int CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_clear,
  input  logic [COLOR_W-1:0]             i_clear_color,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [TEX_H*TEX_W*COLOR_W-1:0] i_texture_data,
  input  logic [POS_W-1:0]               i_start_x,
  input  logic [POS_W-1:0]               i_start_y,
  input  logic [DEPTH_W-1:0]             i_position_z,
  input  logic [1:0]                     i_mode,
  input  logic                           i_key_en,
  input  logic [COLOR_W-1:0]             i_color_key,
  output logic [COLOR_W-1:0]             o_color,
  output logic [DEPTH_W-1:0]             o_depth,
  output logic [CNT_W-1:0]               o_write_cnt,
  output logic                           o_busy
);

  logic                 w_covered;
  logic [COLOR_W-1:0]   w_texel;
  logic                 w_depth_pass;
  logic                 w_transparent;
  logic                 w_write;

  logic                 r_s1_valid;
  logic                 r_s1_covered;
  logic [COLOR_W-1:0]   r_s1_texel;
  logic [DEPTH_W-1:0]   r_s1_z;
  logic [1:0]           r_s1_mode;
  logic                 r_s1_key_en;
  logic [COLOR_W-1:0]   r_s1_key;
  logic [COLOR_W-1:0]   r_color;
  logic [DEPTH_W-1:0]   r_depth;
  logic [CNT_W-1:0]     r_write_cnt;

  stream_texel_fetch #(
    .POS_X  (POS_X),
    .POS_Y  (POS_Y),
    .TEX_W  (TEX_W),
    .TEX_H  (TEX_H),
    .COLOR_W(COLOR_W),
    .POS_W  (POS_W)
  ) u_fetch (
    .i_texture_data(i_texture_data),
    .i_start_x     (i_start_x),
    .i_start_y     (i_start_y),
    .o_covered     (w_covered),
    .o_texel       (w_texel)
  );

  // Handshake: a fragment transfers on a rising edge where i_valid && o_ready;
  // o_ready depends only on reset and i_clear, never on i_valid, and there is no backpressure otherwise.
  assign o_ready = !reset && !i_clear;

  always_comb begin
    w_depth_pass = 1'b0;
    case (r_s1_mode)
      DMODE_GE:     w_depth_pass = (r_s1_z >= r_depth);
      DMODE_GT:     w_depth_pass = (r_s1_z > r_depth);
      DMODE_ALWAYS: w_depth_pass = 1'b1;
      default:      w_depth_pass = 1'b0;
    endcase
    // A z==0 fragment is background fill and must stay visible even if it matches the key.
    w_transparent = r_s1_key_en && (r_s1_texel == r_s1_key) && (r_s1_z != '0);
    w_write       = r_s1_valid && r_s1_covered && w_depth_pass && !w_transparent;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_covered <= 1'b0;
      r_s1_texel   <= '0;
      r_s1_z       <= '0;
      r_s1_mode    <= DMODE_GE;
      r_s1_key_en  <= 1'b0;
      r_s1_key     <= '0;
      r_color      <= '0;
      r_depth      <= '0;
      r_write_cnt  <= '0;
    end else if (i_clear) begin
      r_s1_valid  <= 1'b0;
      r_color     <= i_clear_color;
      r_depth     <= '0;
      r_write_cnt <= '0;
    end else begin
      if (w_write) begin
        r_color <= r_s1_texel;
        r_depth <= r_s1_z;
        if (r_write_cnt != '1) r_write_cnt <= r_write_cnt + 1'b1;
      end
      r_s1_valid <= i_valid;
      if (i_valid) begin
        r_s1_covered <= w_covered;
        r_s1_texel   <= w_texel;
        r_s1_z       <= i_position_z;
        r_s1_mode    <= i_mode;
        r_s1_key_en  <= i_key_en;
        r_s1_key     <= i_color_key;
      end
    end
  end

  assign o_color     = r_color;
  assign o_depth     = r_depth;
  assign o_write_cnt = r_write_cnt;
  assign o_busy      = r_s1_valid;

endmodule

// File: tb/tb_stream_pixel_unit.sv
// Directed bench for stream_pixel_unit at pixel (3,1) with a 2-bit write counter.
module tb_stream_pixel_unit;
  import stream_pixel_unit_pkg::*;

  localparam int TEX_W = 16;
  localparam int TEX_H = 2;
  localparam int NTEX  = TEX_W * TEX_H;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_clear;
  logic [7:0]       i_clear_color;
  logic             i_valid;
  logic             o_ready;
  logic [NTEX*8-1:0] i_texture_data;
  logic [7:0]       i_start_x, i_start_y, i_position_z;
  logic [1:0]       i_mode;
  logic             i_key_en;
  logic [7:0]       i_color_key;
  logic [7:0]       o_color, o_depth;
  logic [1:0]       o_write_cnt;
  logic             o_busy;

  int checks   = 0;
  int failures = 0;

  stream_pixel_unit #(
    .POS_X(3), .POS_Y(1), .TEX_W(TEX_W), .TEX_H(TEX_H),
    .COLOR_W(8), .DEPTH_W(8), .POS_W(8), .CNT_W(2)
  ) dut (
    .clk(clk), .reset(reset), .i_clear(i_clear), .i_clear_color(i_clear_color),
    .i_valid(i_valid), .o_ready(o_ready), .i_texture_data(i_texture_data),
    .i_start_x(i_start_x), .i_start_y(i_start_y), .i_position_z(i_position_z),
    .i_mode(i_mode), .i_key_en(i_key_en), .i_color_key(i_color_key),
    .o_color(o_color), .o_depth(o_depth), .o_write_cnt(o_write_cnt), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic [7:0] clr_color;
    logic [7:0] sx, sy, z;
    logic [1:0] mode;
    logic       key_en;
    logic [7:0] key;
    int         idx;
    logic [7:0] tex;
    logic [7:0] e_color, e_depth;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic clr, logic [7:0] cc, logic [7:0] sx, logic [7:0] sy,
                              logic [7:0] z, logic [1:0] mode, logic ken, logic [7:0] key,
                              int idx, logic [7:0] tex, logic [7:0] ec, logic [7:0] ed,
                              logic [1:0] ecnt);
    vec_t v;
    v.clr = clr; v.clr_color = cc; v.sx = sx; v.sy = sy; v.z = z; v.mode = mode;
    v.key_en = ken; v.key = key; v.idx = idx; v.tex = tex;
    v.e_color = ec; v.e_depth = ed; v.e_cnt = ecnt;
    return v;
  endfunction

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(string tag, logic [7:0] c, logic [7:0] d, logic [1:0] n);
    chk({tag, ".color"}, 32'(o_color), 32'(c));
    chk({tag, ".depth"}, 32'(o_depth), 32'(d));
    chk({tag, ".cnt"},   32'(o_write_cnt), 32'(n));
  endtask

  // Background texel k = 0x80+k so a wrong index shows up as a wrong color.
  task automatic load_tex(int idx, logic [7:0] val);
    for (int k = 0; k < NTEX; k++) i_texture_data[k*8 +: 8] = 8'h80 + 8'(k);
    i_texture_data[idx*8 +: 8] = val;
  endtask

  task automatic drive_frag(logic [7:0] sx, logic [7:0] sy, logic [7:0] z, logic [1:0] mode,
                            logic ken, logic [7:0] key, int idx, logic [7:0] tex);
    i_start_x = sx; i_start_y = sy; i_position_z = z; i_mode = mode;
    i_key_en = ken; i_color_key = key; load_tex(idx, tex);
    i_valid = 1'b1;
  endtask

  task automatic do_clear(logic [7:0] cc);
    i_clear = 1'b1; i_clear_color = cc;
    step();
    i_clear = 1'b0;
  endtask

  logic [7:0] key_ff;

  initial begin
    key_ff = 8'(DEFAULT_COLOR_KEY);
    reset = 1'b1; i_clear = 1'b0; i_clear_color = '0; i_valid = 1'b0;
    i_start_x = '0; i_start_y = '0; i_position_z = '0; i_mode = DMODE_GE;
    i_key_en = 1'b0; i_color_key = '0; load_tex(0, 8'h00);

    // Pixel is (3,1): start (3,1) selects texel 0, start (1,0) selects texel 18.
    vecs[0]  = mk(0, 0,     3, 1, 5,  DMODE_GE,     0, 0,      0,  8'h2A, 8'h2A, 5, 1);
    vecs[1]  = mk(0, 0,     3, 1, 5,  DMODE_GT,     0, 0,      0,  8'h33, 8'h2A, 5, 1);
    vecs[2]  = mk(0, 0,     3, 1, 5,  DMODE_GE,     0, 0,      0,  8'h33, 8'h33, 5, 2);
    vecs[3]  = mk(0, 0,     3, 1, 9,  DMODE_NEVER,  0, 0,      0,  8'h44, 8'h33, 5, 2);
    vecs[4]  = mk(0, 0,     3, 1, 1,  DMODE_ALWAYS, 0, 0,      0,  8'h55, 8'h55, 1, 3);
    vecs[5]  = mk(1, 8'h10, 0, 0, 0,  DMODE_GE,     0, 0,      0,  8'h00, 8'h10, 0, 0);
    vecs[6]  = mk(0, 0,     3, 1, 7,  DMODE_GE,     1, key_ff, 0,  8'hFF, 8'h10, 0, 0);
    vecs[7]  = mk(0, 0,     3, 1, 0,  DMODE_GE,     1, key_ff, 0,  8'hFF, 8'hFF, 0, 1);
    vecs[8]  = mk(0, 0,     3, 1, 7,  DMODE_GE,     1, key_ff, 0,  8'h7E, 8'h7E, 7, 2);
    vecs[9]  = mk(0, 0,     1, 0, 8,  DMODE_GE,     0, 0,      18, 8'h99, 8'h99, 8, 3);
    vecs[10] = mk(0, 0,     4, 1, 9,  DMODE_ALWAYS, 0, 0,      0,  8'hA1, 8'h99, 8, 3);
    vecs[11] = mk(0, 0,     3, 2, 10, DMODE_ALWAYS, 0, 0,      0,  8'hA2, 8'h99, 8, 3);

    step(); step();
    chk_out("reset", 8'h00, 8'h00, 2'd0);
    chk("reset.ready", 32'(o_ready), 32'd0);
    chk("reset.busy",  32'(o_busy),  32'd0);
    reset = 1'b0;
    #1;
    chk("idle.ready", 32'(o_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].clr) begin
        do_clear(vecs[i].clr_color);
      end else begin
        drive_frag(vecs[i].sx, vecs[i].sy, vecs[i].z, vecs[i].mode,
                   vecs[i].key_en, vecs[i].key, vecs[i].idx, vecs[i].tex);
        step();
        i_valid = 1'b0;
        step();
      end
      chk_out($sformatf("vec%0d", i), vecs[i].e_color, vecs[i].e_depth, vecs[i].e_cnt);
    end

    // Uncovered fragment: busy for exactly one cycle, nothing written.
    drive_frag(4, 1, 50, DMODE_ALWAYS, 0, 0, 0, 8'hB0);
    step();
    i_valid = 1'b0;
    chk("cov.busy_hi", 32'(o_busy), 32'd1);
    step();
    chk("cov.busy_lo", 32'(o_busy), 32'd0);
    chk_out("cov", 8'h99, 8'd8, 2'd3);

    // Clear while a passing fragment sits in stage 1; a fragment offered during clear is refused.
    do_clear(8'h00);
    drive_frag(3, 1, 20, DMODE_ALWAYS, 0, 0, 0, 8'h66);
    step();
    chk("clr.busy_inflight", 32'(o_busy), 32'd1);
    i_clear = 1'b1; i_clear_color = 8'h10;
    drive_frag(3, 1, 30, DMODE_ALWAYS, 0, 0, 0, 8'h67);
    #1;
    chk("clr.ready", 32'(o_ready), 32'd0);
    step();
    i_clear = 1'b0; i_valid = 1'b0;
    chk_out("clr", 8'h10, 8'h00, 2'd0);
    chk("clr.busy", 32'(o_busy), 32'd0);
    step();
    chk_out("clr.after", 8'h10, 8'h00, 2'd0);

    // Back-to-back z=1..5 (GT) then z=4 (GE) which must see depth 5 and fail.
    for (int j = 1; j <= 6; j++) begin
      if (j <= 5) drive_frag(3, 1, 8'(j), DMODE_GT, 0, 0, 0, 8'hC0 + 8'(j));
      else        drive_frag(3, 1, 8'd4, DMODE_GE, 0, 0, 0, 8'hD4);
      step();
    end
    i_valid = 1'b0;
    step();
    chk_out("sat", 8'hC5, 8'd5, 2'd3);

    // Reset during a stream drops the in-flight fragment.
    drive_frag(3, 1, 200, DMODE_ALWAYS, 0, 0, 0, 8'hE0);
    step();
    reset = 1'b1;
    #1;
    chk("rst.ready", 32'(o_ready), 32'd0);
    step();
    i_valid = 1'b0;
    chk_out("rst", 8'h00, 8'h00, 2'd0);
    chk("rst.busy", 32'(o_busy), 32'd0);

    // Reset beats clear in the same cycle.
    i_clear = 1'b1; i_clear_color = 8'h5A;
    step();
    i_clear = 1'b0; reset = 1'b0;
    chk_out("rst_clr", 8'h00, 8'h00, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
